// File: rtl/map_query_arbiter.sv
// rtl/map_query_arbiter.sv - round-robin arbiter sharing one map tile-lookup port among N requesters
module map_query_arbiter #(
    parameter int          N         = 5,
    parameter int          MAP_LAT   = 2,
    parameter logic [2:0]  WALL_TYPE = 3'b010
) (
    input  logic              clk_13,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic [10*N-1:0]   req_r,
    input  logic [10*N-1:0]   req_c,
    input  logic              flush,
    output logic [9:0]        map_r,
    output logic [9:0]        map_c,
    input  logic [2:0]        map_type,
    output logic [N-1:0]      ack,
    output logic [2:0]        resp_type,
    output logic              busy,
    output logic [2:0]        grant_idx
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_WAIT   = 1'b1;
    localparam logic [3:0] CNT_INIT = 4'(MAP_LAT - 1);
    localparam logic [2:0] LAST_IDX = 3'(N - 1);

    logic [0:0] state;
    logic [3:0] cnt;
    logic [2:0] ptr;
    logic [2:0] win;
    logic [2:0] win_next;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                win = 3'((int'(ptr) + k) % N);
            end
        end
        win_next = (win == LAST_IDX) ? 3'd0 : win + 3'd1;
    end

    always_ff @(posedge clk_13 or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ptr       <= '0;
            map_r     <= '0;
            map_c     <= '0;
            ack       <= '0;
            resp_type <= WALL_TYPE;
            busy      <= 1'b0;
            grant_idx <= '0;
        end else begin
            ack <= '0;
            if (flush) begin
                state     <= S_IDLE;
                busy      <= 1'b0;
                resp_type <= WALL_TYPE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (req != '0) begin
                            map_r     <= req_r[10*win +: 10];
                            map_c     <= req_c[10*win +: 10];
                            grant_idx <= win;
                            ptr       <= win_next;
                            cnt       <= CNT_INIT;
                            busy      <= 1'b1;
                            state     <= S_WAIT;
                        end
                    end
                    default: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 4'd1;
                        end else begin
                            resp_type <= map_type;
                            ack       <= {{(N-1){1'b0}}, 1'b1} << grant_idx;
                            busy      <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_map_query_arbiter.sv
// tb/tb_map_query_arbiter.sv - scoreboard bench for map_query_arbiter
module tb_map_query_arbiter;

    localparam int N = 5;

    logic            clk_13 = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [10*N-1:0] req_r;
    logic [10*N-1:0] req_c;
    logic            flush;
    logic [9:0]      map_r;
    logic [9:0]      map_c;
    logic [2:0]      map_type;
    logic [N-1:0]    ack;
    logic [2:0]      resp_type;
    logic            busy;
    logic [2:0]      grant_idx;

    logic [9:0] rr [N];
    logic [9:0] cc [N];

    typedef struct {
        int         idx;
        logic [2:0] t;
    } exp_t;

    exp_t sb[$];
    int   ack_cyc[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    map_query_arbiter #(.N(N), .MAP_LAT(2), .WALL_TYPE(3'b010)) dut (
        .clk_13    (clk_13),
        .rst       (rst),
        .req       (req),
        .req_r     (req_r),
        .req_c     (req_c),
        .flush     (flush),
        .map_r     (map_r),
        .map_c     (map_c),
        .map_type  (map_type),
        .ack       (ack),
        .resp_type (resp_type),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    always #5 clk_13 = ~clk_13;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_r[10*i +: 10] = rr[i];
            req_c[10*i +: 10] = cc[i];
        end
    end

    function automatic logic [2:0] tile(input logic [9:0] r, input logic [9:0] c);
        logic [9:0] s;
        s = r + c + 10'd3;
        return s[2:0];
    endfunction

    // Map memory model: address registered at one edge is visible at the next (MAP_LAT=2).
    always @(posedge clk_13) begin
        map_type <= tile(map_r, map_c);
        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk_13) begin
        if (!rst && ack != '0) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("ack_onehot", 32'(ack), 32'(1) << e.idx);
                check_eq("resp_type", 32'(resp_type), 32'(e.t));
                ack_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk_13);
        #1;
    endtask

    task automatic expect_grant(input int i);
        exp_t e;
        e.idx = i;
        e.t   = tile(rr[i], cc[i]);
        sb.push_back(e);
    endtask

    task automatic default_coords();
        for (int i = 0; i < N; i++) begin
            rr[i] = 10'(10 + i);
            cc[i] = 10'(20 + 3 * i);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        flush = 1'b0;
        default_coords();
        repeat (2) tick();
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_map_r", 32'(map_r), 32'd0);
        check_eq("rst_map_c", 32'(map_c), 32'd0);
        check_eq("rst_resp", 32'(resp_type), 32'd2);
        check_eq("rst_grant", 32'(grant_idx), 32'd0);
        rst = 1'b0;
        tick();

        // Single query, latency and busy width
        rr[0] = 10'd2; cc[0] = 10'd3;
        req = 5'b00001;
        expect_grant(0);
        tick();
        check_eq("t1_map_r", 32'(map_r), 32'd2);
        check_eq("t1_map_c", 32'(map_c), 32'd3);
        check_eq("t1_busy0", 32'(busy), 32'd1);
        req = '0;
        tick();
        check_eq("t1_busy1", 32'(busy), 32'd1);
        tick();
        check_eq("t1_busy2", 32'(busy), 32'd0);
        tick();
        check_eq("t1_sb", 32'(sb.size()), 32'd0);

        // All requesters held: strict rotation, one ack per 3 cycles
        default_coords();
        do_reset();
        ack_cyc.delete();
        req = 5'b11111;
        for (int g = 0; g < 6; g++) begin
            expect_grant(g % N);
            tick();
            check_eq("t2_grant", 32'(grant_idx), 32'(g % N));
            if (g == 5) req = '0;
            if (g < 5) repeat (2) tick();
        end
        repeat (3) tick();
        check_eq("t2_acks", 32'(ack_cyc.size()), 32'd6);
        for (int i = 1; i < ack_cyc.size(); i++) begin
            check_eq("t2_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        end

        // Wrap: grant 3 then req=01001 gives 0 then 3
        req = 5'b01000;
        expect_grant(3);
        tick();
        check_eq("t3_grant3", 32'(grant_idx), 32'd3);
        req = 5'b01001;
        expect_grant(0);
        expect_grant(3);
        repeat (3) tick();
        check_eq("t3_grant0", 32'(grant_idx), 32'd0);
        repeat (3) tick();
        check_eq("t3_grant3b", 32'(grant_idx), 32'd3);
        req = '0;
        repeat (3) tick();

        // Address latched at grant
        rr[1] = 10'd5; cc[1] = 10'd7;
        req = 5'b00010;
        expect_grant(1);
        tick();
        rr[1] = 10'd9;
        req = '0;
        tick();
        check_eq("t4_map_r", 32'(map_r), 32'd5);
        tick();
        check_eq("t4_map_r2", 32'(map_r), 32'd5);
        tick();
        check_eq("t4_resp", 32'(resp_type), 32'(tile(10'd5, 10'd7)));

        // Flush during WAIT
        req = 5'b00100;
        tick();
        check_eq("t5_grant", 32'(grant_idx), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_resp", 32'(resp_type), 32'd2);
        check_eq("t5_ack", 32'(ack), 32'd0);
        expect_grant(2);
        tick();
        check_eq("t5_regrant", 32'(grant_idx), 32'd2);
        check_eq("t5_busy2", 32'(busy), 32'd1);
        req = '0;
        repeat (3) tick();

        // Asynchronous reset mid-WAIT
        req = 5'b00001;
        tick();
        req = '0;
        #3;
        rst = 1'b1;
        #1;
        check_eq("t6_busy", 32'(busy), 32'd0);
        check_eq("t6_map_r", 32'(map_r), 32'd0);
        check_eq("t6_map_c", 32'(map_c), 32'd0);
        check_eq("t6_resp", 32'(resp_type), 32'd2);
        check_eq("t6_grant", 32'(grant_idx), 32'd0);
        check_eq("t6_ack", 32'(ack), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();
        req = 5'b00010;
        expect_grant(1);
        tick();
        check_eq("t6_newgrant", 32'(grant_idx), 32'd1);
        req = '0;
        repeat (3) tick();

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
